// File: rtl/wb_regfile_pkg.sv
// Shared types and helpers for the LC3 writeback / register-file stage.
package wb_regfile_pkg;

  // Writeback source select encoding.
  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_PC  = 2'd1,
    WSEL_MEM = 2'd2,
    WSEL_ILL = 2'd3
  } wsel_t;

  // Condition-code width and bit positions within psr ({N,Z,P}).
  localparam int PSR_W = 3;
  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  // Condition codes from the sign bit and a non-zero flag of the written value.
  // Taking the two reduced flags keeps the helper independent of DATA_W.
  function automatic logic [PSR_W-1:0] calc_nzp(input logic msb, input logic nonzero);
    logic [PSR_W-1:0] v_nzp;
    v_nzp        = {PSR_W{1'b0}};
    v_nzp[PSR_N] = msb;
    v_nzp[PSR_Z] = ~nonzero;
    v_nzp[PSR_P] = ~msb & nonzero;
    return v_nzp;
  endfunction

endpackage

// File: rtl/wb_regfile_core.sv
// Register array: one write port, two registered read ports with write-first bypass.
module wb_regfile_core #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;

  // Register writes and registered reads; a same-cycle write to the read index wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
      r_rdata1 <= {DATA_W{1'b0}};
      r_rdata2 <= {DATA_W{1'b0}};
    end else begin
      if (i_we) begin
        r_regs[i_waddr] <= i_wdata;
      end
      r_rdata1 <= (i_we && (i_raddr1 == i_waddr)) ? i_wdata : r_regs[i_raddr1];
      r_rdata2 <= (i_we && (i_raddr2 == i_waddr)) ? i_wdata : r_regs[i_raddr2];
    end
  end

  assign o_rdata1 = r_rdata1;
  assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/wb_regfile_stage.sv
// LC3 writeback stage: source mux, register commit, condition codes, error pulse, commit counter.
module wb_regfile_stage
  import wb_regfile_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [PSR_W-1:0]  psr,
  output logic              wb_err,
  output logic [15:0]       wb_count
);

  wsel_t             w_sel;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic              w_illegal;

  logic [PSR_W-1:0]  r_psr;
  logic              r_wb_err;
  logic [15:0]       r_wb_count;

  assign w_sel     = wsel_t'(W_Control);
  assign w_commit  = enable_writeback && (w_sel != WSEL_ILL);
  assign w_illegal = enable_writeback && (w_sel == WSEL_ILL);

  // Writeback source mux; the illegal encoding drives zero and is never committed.
  always_comb begin
    w_wb_data = {DATA_W{1'b0}};
    case (w_sel)
      WSEL_ALU: w_wb_data = aluout;
      WSEL_PC:  w_wb_data = pcout;
      WSEL_MEM: w_wb_data = memout;
      WSEL_ILL: w_wb_data = {DATA_W{1'b0}};
      default:  w_wb_data = {DATA_W{1'b0}};
    endcase
  end

  // Condition codes, error pulse and commit counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_psr      <= {PSR_W{1'b0}};
      r_wb_err   <= 1'b0;
      r_wb_count <= 16'd0;
    end else begin
      r_wb_err <= w_illegal;
      if (w_commit) begin
        r_psr      <= calc_nzp(w_wb_data[DATA_W-1], |w_wb_data);
        r_wb_count <= r_wb_count + 16'd1;
      end
    end
  end

  wb_regfile_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_commit),
    .i_waddr  (dr),
    .i_wdata  (w_wb_data),
    .i_raddr1 (sr1),
    .i_raddr2 (sr2),
    .o_rdata1 (VSR1),
    .o_rdata2 (VSR2)
  );

  assign psr      = r_psr;
  assign wb_err   = r_wb_err;
  assign wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: reference model feeds a scoreboard queue.
module tb_wb_regfile_stage;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  logic              clock;
  logic              reset;
  logic              enable_writeback;
  logic [1:0]        W_Control;
  logic [DATA_W-1:0] aluout, pcout, memout;
  logic [ADDR_W-1:0] dr, sr1, sr2;
  logic [DATA_W-1:0] VSR1, VSR2;
  logic [2:0]        psr;
  logic              wb_err;
  logic [15:0]       wb_count;

  typedef struct {
    logic [DATA_W-1:0] vsr1;
    logic [DATA_W-1:0] vsr2;
    logic [2:0]        psr;
    logic              err;
    logic [15:0]       cnt;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [2:0]        m_psr;
  logic [15:0]       m_cnt;
  int                n_checks = 0;
  int                n_errors = 0;
  bit                chk_en   = 1'b1;

  wb_regfile_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
    .W_Control(W_Control), .aluout(aluout), .pcout(pcout), .memout(memout),
    .dr(dr), .sr1(sr1), .sr2(sr2), .VSR1(VSR1), .VSR2(VSR2),
    .psr(psr), .wb_err(wb_err), .wb_count(wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model one clock edge from the current inputs, push the expectation, then compare.
  task automatic step();
    exp_t        e;
    logic [15:0] d;
    logic        legal;
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0000;
      m_psr = 3'b000;
      m_cnt = 16'h0000;
      e.vsr1 = 16'h0000; e.vsr2 = 16'h0000; e.err = 1'b0;
    end else begin
      legal = enable_writeback && (W_Control != 2'd3);
      case (W_Control)
        2'd0:    d = aluout;
        2'd1:    d = pcout;
        2'd2:    d = memout;
        default: d = 16'h0000;
      endcase
      e.vsr1 = (legal && sr1 == dr) ? d : m_regs[sr1];
      e.vsr2 = (legal && sr2 == dr) ? d : m_regs[sr2];
      e.err  = enable_writeback && (W_Control == 2'd3);
      if (legal) begin
        m_regs[dr] = d;
        m_psr = {d[15], d == 16'h0000, !d[15] && d != 16'h0000};
        m_cnt = m_cnt + 16'd1;
      end
    end
    e.psr = m_psr;
    e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    if (chk_en) begin
      check("VSR1", 32'(VSR1), 32'(e.vsr1));
      check("VSR2", 32'(VSR2), 32'(e.vsr2));
      check("psr", 32'(psr), 32'(e.psr));
      check("wb_err", 32'(wb_err), 32'(e.err));
      check("wb_count", 32'(wb_count), 32'(e.cnt));
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] wc, input logic [15:0] alu,
                       input logic [15:0] pc, input logic [15:0] mem,
                       input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    enable_writeback = en; W_Control = wc; aluout = alu; pcout = pc; memout = mem;
    dr = d; sr1 = s1; sr2 = s2;
    step();
  endtask

  initial begin
    reset = 1'b0;
    // Reset with a pending commit: must be ignored.
    drive(1'b1, 2'd0, 16'h1234, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0);
    drive(1'b1, 2'd0, 16'h1234, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd7);
    check("reset_psr", 32'(psr), 32'h0);
    check("reset_cnt", 32'(wb_count), 32'h0);

    // ALU write to R3 then read it back.
    drive(1'b1, 2'd0, 16'h8001, 16'h0000, 16'h0000, 3'd3, 3'd0, 3'd1);
    check("alu_psr_neg", 32'(psr), 32'h4);
    drive(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd3, 3'd0);
    check("alu_readback", 32'(VSR1), 32'h8001);

    // Zero from memory, then positive from PC into R5.
    drive(1'b1, 2'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 3'd5, 3'd3, 3'd3);
    check("zero_psr", 32'(psr), 32'h2);
    drive(1'b1, 2'd1, 16'hFFFF, 16'h0042, 16'h1111, 3'd5, 3'd0, 3'd0);
    check("pos_psr", 32'(psr), 32'h1);
    drive(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd5, 3'd3);
    check("r5_value", 32'(VSR1), 32'h0042);

    // Bypass on both read ports.
    drive(1'b1, 2'd0, 16'hBEEF, 16'h0000, 16'h0000, 3'd2, 3'd2, 3'd2);
    check("bypass_vsr1", 32'(VSR1), 32'hBEEF);
    check("bypass_vsr2", 32'(VSR2), 32'hBEEF);
    // Bypass on one port only, stale-free read on the other.
    drive(1'b1, 2'd2, 16'h0000, 16'h0000, 16'h7ABC, 3'd6, 3'd6, 3'd2);
    drive(1'b1, 2'd0, 16'h0101, 16'h0000, 16'h0000, 3'd1, 3'd2, 3'd6);
    // Back-to-back writes to the same register.
    drive(1'b1, 2'd0, 16'h0005, 16'h0000, 16'h0000, 3'd4, 3'd0, 3'd0);
    drive(1'b1, 2'd0, 16'hF000, 16'h0000, 16'h0000, 3'd4, 3'd0, 3'd0);
    drive(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd4, 3'd4);
    check("last_write_wins", 32'(VSR2), 32'hF000);

    // Illegal select into R1: one-cycle error, nothing else moves.
    drive(1'b1, 2'd3, 16'h5555, 16'h5555, 16'h5555, 3'd1, 3'd1, 3'd1);
    check("illegal_err", 32'(wb_err), 32'h1);
    check("illegal_r1", 32'(VSR1), 32'h0101);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    check("idle_err_clear", 32'(wb_err), 32'h0);

    // Random legal/illegal mix.
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
    end

    // Run the counter up to 16'hFFFF without per-cycle comparison, then wrap.
    chk_en = 1'b0;
    while (m_cnt != 16'hFFFF) begin
      drive(1'b1, 2'd0, 16'h0001, 16'h0000, 16'h0000, 3'd7, 3'd0, 3'd0);
    end
    chk_en = 1'b1;
    check("preload_cnt", 32'(wb_count), 32'hFFFF);
    drive(1'b1, 2'd1, 16'h0000, 16'h8000, 16'h0000, 3'd0, 3'd0, 3'd1);
    check("wrap_cnt", 32'(wb_count), 32'h0);
    check("wrap_psr", 32'(psr), 32'h4);

    // Commit coincident with reset is dropped.
    reset = 1'b0;
    drive(1'b1, 2'd0, 16'h7777, 16'h0000, 16'h0000, 3'd6, 3'd6, 3'd0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd6, 3'd0);
    check("midreset_r6", 32'(VSR1), 32'h0);
    check("midreset_r0", 32'(VSR2), 32'h0);
    check("midreset_psr", 32'(psr), 32'h0);
    check("midreset_cnt", 32'(wb_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
